// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit feeding the architectural HI/LO
// registers of the toy MIPS pipeline. MULT/MULTU use shift-add, DIV/DIVU use
// restoring division; both take 32 CALC cycles plus one FIX cycle for signs.
// MTHI/MTLO are single-cycle writes that never raise busy_o.
module md_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [5:0]    func_i,
  input  logic [DW-1:0] rs_i,
  input  logic [DW-1:0] rt_i,
  input  logic          flush_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state;
  logic [4:0]      cnt;
  // acc: multiply upper half plus carry, or divide partial remainder
  logic [DW:0]     acc;
  // low: multiplier being shifted out, or dividend shifted out / quotient in
  logic [DW-1:0]   low;
  // opb: multiplicand magnitude, or divisor magnitude
  logic [DW-1:0]   opb;
  logic            is_div;
  logic            neg_main;
  logic            neg_rem;
  logic            div_zero;

  logic            op_signed;
  logic            op_is_div;
  logic [DW-1:0]   rs_mag;
  logic [DW-1:0]   rt_mag;
  logic [DW:0]     mul_sum;
  logic [DW:0]     div_trial;
  logic [DW:0]     div_diff;
  logic [2*DW-1:0] product;

  function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v);
    return v[DW-1] ? -v : v;
  endfunction

  assign busy_o = (state != IDLE);

  // Datapath helpers: operand magnitudes plus one step of each algorithm
  always_comb begin
    op_signed = ~func_i[0];
    op_is_div = func_i[1];
    rs_mag    = op_signed ? magnitude(rs_i) : rs_i;
    rt_mag    = op_signed ? magnitude(rt_i) : rt_i;
    mul_sum   = low[0] ? (acc + {1'b0, opb}) : acc;
    div_trial = {acc[DW-1:0], low[DW-1]};
    div_diff  = div_trial - {1'b0, opb};
    product   = {acc[DW-1:0], low};
  end

  // Control FSM and all registered state: flush beats everything, start is
  // only looked at in IDLE so a busy unit silently ignores new requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      low      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done_o   <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              case (func_i)
                FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: begin
                  low      <= op_is_div ? rs_mag : rt_mag;
                  opb      <= op_is_div ? rt_mag : rs_mag;
                  acc      <= '0;
                  cnt      <= '0;
                  is_div   <= op_is_div;
                  neg_main <= op_signed & (rs_i[DW-1] ^ rt_i[DW-1]);
                  neg_rem  <= op_signed & rs_i[DW-1];
                  div_zero <= (rt_i == '0);
                  state    <= CALC;
                end
                FUNC_MTHI: hi_o <= rs_i;
                FUNC_MTLO: lo_o <= rs_i;
                default: ;
              endcase
            end
          end
          CALC: begin
            if (is_div) begin
              if (!div_diff[DW]) begin
                acc <= div_diff;
                low <= {low[DW-2:0], 1'b1};
              end else begin
                acc <= div_trial;
                low <= {low[DW-2:0], 1'b0};
              end
            end else begin
              {acc, low} <= {1'b0, mul_sum, low[DW-1:1]};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state <= FIX;
            end
          end
          FIX: begin
            if (is_div) begin
              hi_o <= neg_rem ? -acc[DW-1:0] : acc[DW-1:0];
              lo_o <= div_zero ? '1 : (neg_main ? -low : low);
            end else begin
              {hi_o, lo_o} <= neg_main ? -product : product;
            end
            done_o <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit. MULT/DIV results are
// predicted by a plain-arithmetic model and queued; a monitor pops and compares
// whenever done_o pulses. MTHI/MTLO, flush, reset and timing are checked inline.
module tb_md_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [5:0]  func_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int          checks;
  int          failures;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  int          busy_cycles;
  int          done_pulses;
  logic [5:0]  func_tab[7];

  md_unit #(.DW(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .func_i  (func_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: {HI, LO} for a MULT/DIV family op using 64-bit arithmetic
  function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = '0;
    case (f)
      6'h18: res = 64'(sa * sb);
      6'h19: res = ua * ub;
      6'h1A: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      6'h1B: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Wait (bounded) until the unit reports idle; leaves time at posedge+1
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check_output("wait_idle_timeout", 64'(busy_o), 64'd0);
  endtask

  // Issue one instruction as soon as the unit is idle and check acceptance
  task automatic apply_stimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic is_md;
    wait_idle();
    is_md   = (f >= 6'h18 && f <= 6'h1B);
    start_i = 1'b1;
    func_i  = f;
    rs_i    = a;
    rt_i    = b;
    if (is_md) begin
      exp_q.push_back(ref_model(f, a, b));
      {model_hi, model_lo} = ref_model(f, a, b);
    end else if (f == 6'h11) begin
      model_hi = a;
    end else if (f == 6'h13) begin
      model_lo = a;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (is_md) begin
      check_output("busy_after_start", 64'(busy_o), 64'd1);
    end else begin
      check_output("busy_mt_or_nop", 64'(busy_o), 64'd0);
      check_output("hi_after_mt", 64'(hi_o), 64'(model_hi));
      check_output("lo_after_mt", 64'(lo_o), 64'(model_lo));
    end
  endtask

  // Wait for a directed MULT/DIV to finish and compare against literal values
  task automatic check_result(input string name, input logic [31:0] hi_exp,
                              input logic [31:0] lo_exp);
    wait_idle();
    check_output({name, "_hi"}, 64'(hi_o), 64'(hi_exp));
    check_output({name, "_lo"}, 64'(lo_o), 64'(lo_exp));
  endtask

  // Start a multiply that is expected to be aborted, so nothing is queued
  task automatic start_doomed_mult();
    wait_idle();
    start_i = 1'b1;
    func_i  = 6'h18;
    rs_i    = 32'd3;
    rt_i    = 32'd4;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Scoreboard monitor: every done_o pulse must match the oldest queued result
  always @(negedge clk) begin
    if (rst_n && done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_done", 64'(done_o), 64'd0);
      end else begin
        check_output("scoreboard_hilo", {hi_o, lo_o}, exp_q.pop_front());
      end
    end
  end

  // Watchdog so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] specials[5];
    checks      = 0;
    failures    = 0;
    model_hi    = '0;
    model_lo    = '0;
    busy_cycles = 0;
    done_pulses = 0;
    func_tab    = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h00};
    specials    = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0};
    rst_n       = 1'b0;
    start_i     = 1'b0;
    func_i      = '0;
    rs_i        = '0;
    rt_i        = '0;
    flush_i     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_output("reset_hi", 64'(hi_o), 64'd0);
    check_output("reset_lo", 64'(lo_o), 64'd0);
    check_output("reset_busy", 64'(busy_o), 64'd0);
    check_output("reset_done", 64'(done_o), 64'd0);

    $display("[TB] back-to-back MTHI/MTLO");
    apply_stimulus(6'h11, 32'h1234_5678, 32'd0);
    apply_stimulus(6'h13, 32'h9ABC_DEF0, 32'd0);
    check_output("mthi_value", 64'(hi_o), 64'h1234_5678);
    check_output("mtlo_value", 64'(lo_o), 64'h9ABC_DEF0);

    $display("[TB] MULT signed with latency check");
    apply_stimulus(6'h18, 32'hFFFF_FFFD, 32'd7);
    busy_cycles = 0;
    done_pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy_o === 1'b1) busy_cycles++;
      if (done_o === 1'b1) done_pulses++;
    end
    check_output("mult_busy_cycles", 64'(busy_cycles), 64'd33);
    check_output("mult_done_pulses", 64'(done_pulses), 64'd1);
    check_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    $display("[TB] directed MULTU/DIV/DIVU");
    apply_stimulus(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    apply_stimulus(6'h1A, 32'hFFFF_FFF9, 32'd2);
    check_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    apply_stimulus(6'h1B, 32'd100, 32'd7);
    check_result("divu_100_7", 32'd2, 32'd14);
    apply_stimulus(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    check_result("div_overflow", 32'd0, 32'h8000_0000);
    apply_stimulus(6'h1B, 32'd5, 32'd0);
    check_result("divu_by_zero", 32'd5, 32'hFFFF_FFFF);
    apply_stimulus(6'h1A, 32'hFFFF_FFF0, 32'd0);
    check_result("div_by_zero_neg", 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    $display("[TB] flush and start-while-busy");
    start_doomed_mult();
    repeat (4) @(posedge clk);
    #1;
    start_i = 1'b1;
    func_i  = 6'h11;
    rs_i    = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check_output("busy_ignores_start", 64'(busy_o), 64'd1);
    check_output("busy_ignores_mthi", 64'(hi_o), 64'(model_hi));
    repeat (3) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check_output("flush_busy", 64'(busy_o), 64'd0);
    check_output("flush_hi", 64'(hi_o), 64'(model_hi));
    check_output("flush_lo", 64'(lo_o), 64'(model_lo));
    done_pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o === 1'b1) done_pulses++;
    end
    check_output("flush_no_done", 64'(done_pulses), 64'd0);
    flush_i = 1'b1;
    start_i = 1'b1;
    func_i  = 6'h11;
    rs_i    = 32'hCAFE_BABE;
    @(posedge clk);
    #1;
    func_i = 6'h1B;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    check_output("flush_blocks_mthi", 64'(hi_o), 64'(model_hi));
    check_output("flush_blocks_start", 64'(busy_o), 64'd0);

    $display("[TB] reset in the middle of an operation");
    start_doomed_mult();
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midreset_hi", 64'(hi_o), 64'd0);
    check_output("midreset_lo", 64'(lo_o), 64'd0);
    check_output("midreset_busy", 64'(busy_o), 64'd0);
    check_output("midreset_done", 64'(done_o), 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      apply_stimulus(func_tab[$urandom_range(0, 6)], a, b);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check_output("queue_drained", 64'(exp_q.size()), 64'd0);
    check_output("final_hi", 64'(hi_o), 64'(model_hi));
    check_output("final_lo", 64'(lo_o), 64'(model_lo));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
